// File: rtl/render_pixel_sequencer.sv
// Raster-order pixel coordinate walker feeding an AXI4-Stream master.
// Optional stall counter enabled by defining RENDER_SEQ_STALL_CNT_EN.
module render_pixel_sequencer #(
  parameter int COORD_W = 12
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  output logic               status_busy,
  output logic               status_done,
  output logic               status_err,
  output logic [31:0]        status_stall_cnt,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic [31:0]        M_AXIS_TDATA,
  output logic               M_AXIS_TUSER,
  output logic               M_AXIS_TLAST
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [COORD_W-1:0] ONE = 1;

  logic [1:0]         state;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] width_q;
  logic [COORD_W-1:0] height_q;
  logic               start_q;
  logic               start_armed;
  logic               first_sent;
  logic               abort_pending;
  logic               done_q;
  logic               err_q;

  logic start_edge;
  logic cfg_zero;
  logic accept;
  logic hs;
  logic x_end;
  logic y_end;
  logic in_run;

  // A level already high when reset releases must drop before it counts
  assign start_edge = cfg_start & ~start_q & start_armed;
  assign cfg_zero   = (cfg_width == '0) | (cfg_height == '0);
  assign accept     = (state == S_IDLE) & start_edge & ~cfg_zero;
  assign in_run     = (state == S_RUN);
  assign hs         = in_run & M_AXIS_TREADY;
  assign x_end      = (x_q == width_q - ONE);
  assign y_end      = (y_q == height_q - ONE);

  assign status_busy   = in_run;
  assign status_done   = done_q;
  assign status_err    = err_q;
  assign M_AXIS_TVALID = in_run;
  assign M_AXIS_TDATA  = {16'(y_q), 16'(x_q)};
  assign M_AXIS_TUSER  = in_run & (x_q == '0) & (y_q == '0) & ~first_sent;
  assign M_AXIS_TLAST  = in_run & (x_end | abort_pending);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q <= cfg_start;
      if (!cfg_start) start_armed <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      width_q       <= '0;
      height_q      <= '0;
      first_sent    <= 1'b0;
      abort_pending <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_edge && cfg_zero) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (start_edge) begin
            width_q       <= cfg_width;
            height_q      <= cfg_height;
            x_q           <= '0;
            y_q           <= '0;
            first_sent    <= 1'b0;
            abort_pending <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_abort) abort_pending <= 1'b1;
          if (hs) begin
            first_sent <= 1'b1;
            // Terminal beat holds coordinates so they never pass the frame
            if (abort_pending || (x_end && y_end)) begin
              state <= S_DONE;
            end else if (x_end) begin
              x_q <= '0;
              y_q <= y_q + ONE;
            end else begin
              x_q <= x_q + ONE;
            end
          end
        end
        S_DONE: begin
          done_q        <= 1'b1;
          abort_pending <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RENDER_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (in_run && !M_AXIS_TREADY && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign status_stall_cnt = stall_q;
`else
  assign status_stall_cnt = '0;
`endif

endmodule
